booth_accumulator: RTL and testbench

- Downstream stage of the 4-bit signed Booth multiplier: consumes its 8-bit signed product `P` and sums groups of products into one signed result (dot-product / MAC reduction).
- Accepts products on a valid/ready handshake and adds each one into a registered accumulator.
- After `LEN` products, or on an early `flush`, presents the sum plus a beat count on a valid/ready output port.

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_accumulator.sv | 95 +++++++++
 tb/tb_booth_accumulator.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier datapath and its
// downstream product accumulator.
package booth_pkg;

    localparam int PROD_W    = 8;
    localparam int ACC_W_DEF = 12;
    localparam int CNT_W     = 5;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/booth_accumulator.sv
// Sums groups of LEN signed 8-bit products (or fewer on flush) and presents
// each group sum with its beat count on a valid/ready output port.
module booth_accumulator
    import booth_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PROD_W-1:0]       in_p,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [ACC_W-1:0]        out_data,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_valid,
    input  logic                    out_ready
);

    acc_state_t         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;

    logic               beat;
    logic               close;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   count_inc;

    always_comb begin
        beat      = in_valid && (state_q == ACCUM);
        sum       = acc_q;
        count_inc = count_q;
        if (beat) begin
            sum       = acc_q + {{(ACC_W-PROD_W){in_p[PROD_W-1]}}, in_p};
            count_inc = count_q + CNT_W'(1);
        end
        // A flush closes only a non-empty group; a same-cycle beat counts as content.
        close = (state_q == ACCUM) &&
                ((beat && (count_q == CNT_W'(LEN - 1))) ||
                 (flush && (beat || (count_q != '0))));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        unique case (state_q)
            ACCUM: begin
                if (close) begin
                    out_data_d  = sum;
                    out_beats_d = count_inc;
                    acc_d       = '0;
                    count_d     = '0;
                    state_d     = HOLD;
                end else begin
                    acc_d   = sum;
                    count_d = count_inc;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_booth_accumulator.sv
// Bench for booth_accumulator: directed scenarios plus randomized traffic
// checked against a list-of-products reference model.
module tb_booth_accumulator;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_p = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [11:0] out_data;
    logic [4:0]  out_beats;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [7:0]  in16_p = '0;
    logic        in16_valid = 1'b0;
    logic        in16_ready;
    logic        flush16 = 1'b0;
    logic [11:0] out16_data;
    logic [4:0]  out16_beats;
    logic        out16_valid;
    logic        out16_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the open group is a list of products.
    int          m_q[$];
    bit          m_hold = 1'b0;
    logic [11:0] m_data = '0;
    int          m_beats = 0;

    always #5 clk = ~clk;

    booth_accumulator #(.LEN(LEN), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .in_p(in_p), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_beats(out_beats), .out_valid(out_valid), .out_ready(out_ready)
    );

    booth_accumulator #(.LEN(16), .ACC_W(12)) dut16 (
        .clk(clk), .rst(rst), .in_p(in16_p), .in_valid(in16_valid),
        .in_ready(in16_ready), .flush(flush16), .out_data(out16_data),
        .out_beats(out16_beats), .out_valid(out16_valid), .out_ready(out16_ready)
    );

    function automatic void model_reset();
        m_q.delete();
        m_hold  = 1'b0;
        m_data  = '0;
        m_beats = 0;
    endfunction

    function automatic void model_step(bit v, int p, bit f, bit r);
        int s;
        s = 0;
        if (m_hold) begin
            if (r) m_hold = 1'b0;
        end else begin
            if (v) m_q.push_back(p);
            if (m_q.size() == LEN || (f && m_q.size() > 0)) begin
                foreach (m_q[i]) s += m_q[i];
                m_data  = 12'(s);
                m_beats = m_q.size();
                m_q.delete();
                m_hold  = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit v, input int p, input bit f, input bit r);
        in_valid  = v;
        in_p      = 8'(p);
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_step(v, p, f, r);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 12'h000 || out_beats !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b data=%h beats=%0d, want 0/000/0",
                     out_valid, out_data, out_beats);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_full_group();
        int seq[4] = '{6, 64, -56, -15};
        for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'hFFF || out_beats !== 5'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_group: valid=%b data=%h beats=%0d ready=%b, want 1/fff/4/0",
                     out_valid, out_data, out_beats, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, int'($urandom_range(120)) - 56, 1'($urandom), 1'b0);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'hFFF || out_beats !== 5'd4) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b data=%h beats=%0d, want 0/1/fff/4",
                         i, in_ready, out_valid, out_data, out_beats);
            end
        end
        drive(1'b1, 33, 1'b0, 1'b1);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
        for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'd10 || out_beats !== 5'd4) begin
            n_fail++;
            $display("FAIL next_group_from_zero: valid=%b data=%h beats=%0d, want 1/00a/4",
                     out_valid, out_data, out_beats);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_flush_early();
        drive(1'b1, 6, 1'b0, 1'b0);
        drive(1'b1, 64, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'd70 || out_beats !== 5'd2) begin
            n_fail++;
            $display("FAIL flush_early: valid=%b data=%0d beats=%0d, want 1/70/2",
                     out_valid, out_data, out_beats);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_flush_with_beat();
        drive(1'b1, 6, 1'b0, 1'b0);
        drive(1'b1, -8, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'hFFE || out_beats !== 5'd2) begin
            n_fail++;
            $display("FAIL flush_with_beat: valid=%b data=%h beats=%0d, want 1/ffe/2",
                     out_valid, out_data, out_beats);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_flush_empty();
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 12'hFFE) begin
            n_fail++;
            $display("FAIL flush_empty: valid=%b ready=%b data=%h, want 0/1/ffe",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 10, 1'b0, 1'b0);
        drive(1'b1, 20, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 12'h000 || out_beats !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b data=%h beats=%0d, want 0/000/0",
                     out_valid, out_data, out_beats);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'd4 || out_beats !== 5'd4) begin
            n_fail++;
            $display("FAIL reset_mid_group: valid=%b data=%0d beats=%0d, want 1/4/4",
                     out_valid, out_data, out_beats);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit v, f, r;
        int p;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(3) != 0);
            f = ($urandom_range(5) == 0);
            r = ($urandom_range(2) != 0);
            p = int'($urandom_range(120)) - 56;
            drive(v, p, f, r);
            n_tests++;
            if (in_ready !== !m_hold || out_valid !== m_hold ||
                out_data !== m_data || out_beats !== 5'(m_beats)) begin
                n_fail++;
                $display("FAIL random[%0d]: ready=%b valid=%b data=%h beats=%0d, want %b/%b/%h/%0d",
                         i, in_ready, out_valid, out_data, out_beats,
                         !m_hold, m_hold, m_data, m_beats);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_max_range();
        int exp_sum;
        exp_sum = 0;
        in16_valid  = 1'b1;
        in16_p      = 8'd64;
        out16_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            exp_sum += 64;
            #1;
            if (i == 14) begin
                n_tests++;
                if (out16_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL max_range_early: valid=%b after 15 beats, want 0", out16_valid);
                end
            end
        end
        n_tests++;
        if (out16_valid !== 1'b1 || out16_data !== 12'(exp_sum) || out16_beats !== 5'd16) begin
            n_fail++;
            $display("FAIL max_range: valid=%b data=%h beats=%0d, want 1/%h/16",
                     out16_valid, out16_data, out16_beats, 12'(exp_sum));
        end
        in16_valid  = 1'b0;
        out16_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_back_to_back();
        test_flush_early();
        test_flush_with_beat();
        test_flush_empty();
        test_reset_mid();
        test_random();
        test_max_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
